// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU select codes and stage payload types
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // Select codes overlap between modes; op_mode picks the meaning.
    localparam logic [SEL_W-1:0] SEL_ADD = 4'b1001;
    localparam logic [SEL_W-1:0] SEL_SUB = 4'b0110;
    localparam logic [SEL_W-1:0] SEL_XOR = 4'b0110;
    localparam logic [SEL_W-1:0] SEL_AND = 4'b1011;
    localparam logic [SEL_W-1:0] SEL_OR  = 4'b1110;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] sel;
        logic             mode;
        logic             cin;
        logic             chain;
    } op_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             eq;
    } res_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - op, ALU, result and flag signals of the issue stage
interface alu_issue_if;
    import alu_pkg::*;

    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SEL_W-1:0] op_sel;
    logic             op_mode;
    logic             op_cin;
    logic             op_chain;

    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic [SEL_W-1:0] alu_select;
    logic             alu_mode;
    logic             alu_carry_in;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry_out;
    logic             alu_compare;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_eq;

    logic             flag_carry;
    logic             flag_eq;
    logic             flag_clr;

    modport master (
        output op_valid, op_a, op_b, op_sel, op_mode, op_cin, op_chain,
        output alu_result, alu_carry_out, alu_compare,
        output res_ready, flag_clr,
        input  op_ready, alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
        input  res_valid, res_data, res_carry, res_eq, flag_carry, flag_eq
    );

    modport slave (
        input  op_valid, op_a, op_b, op_sel, op_mode, op_cin, op_chain,
        input  alu_result, alu_carry_out, alu_compare,
        input  res_ready, flag_clr,
        output op_ready, alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
        output res_valid, res_data, res_carry, res_eq, flag_carry, flag_eq
    );

endinterface

// File: rtl/alu_pipe_slice.sv
// rtl/alu_pipe_slice.sv - single-entry valid/ready register slice, full throughput
module alu_pipe_slice #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic valid_q, valid_d;
    T     data_q,  data_d;

    // Accepts while empty or while the held entry is leaving on this edge.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-stage issue/retire wrapper around a combinational ALU
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    op_t  op_in, s1_op;
    res_t res_in, s2_res;
    logic s1_valid, s2_valid, s2_en, capture;
    logic flag_carry_q, flag_carry_d;
    logic flag_eq_q, flag_eq_d;

    assign op_in = '{a: bus.op_a, b: bus.op_b, sel: bus.op_sel, mode: bus.op_mode,
                     cin: bus.op_cin, chain: bus.op_chain};

    alu_pipe_slice #(.T(op_t)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.op_valid),
        .in_ready  (bus.op_ready),
        .in_data   (op_in),
        .out_valid (s1_valid),
        .out_ready (s2_en),
        .out_data  (s1_op)
    );

    assign bus.alu_in_a     = s1_op.a;
    assign bus.alu_in_b     = s1_op.b;
    assign bus.alu_select   = s1_op.sel;
    assign bus.alu_mode     = s1_op.mode;
    // A chained op reaches stage 1 only after its predecessor was captured.
    assign bus.alu_carry_in = s1_op.chain ? flag_carry_q : s1_op.cin;

    assign res_in = '{data: bus.alu_result, carry: bus.alu_carry_out, eq: bus.alu_compare};

    alu_pipe_slice #(.T(res_t)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_en),
        .in_data   (res_in),
        .out_valid (s2_valid),
        .out_ready (bus.res_ready),
        .out_data  (s2_res)
    );

    assign bus.res_valid = s2_valid;
    assign bus.res_data  = s2_res.data;
    assign bus.res_carry = s2_res.carry;
    assign bus.res_eq    = s2_res.eq;

    assign capture = s1_valid && s2_en;

    // A capture on the same edge as a clear takes priority.
    always_comb begin
        flag_carry_d = flag_carry_q;
        flag_eq_d    = flag_eq_q;
        if (capture) begin
            flag_carry_d = bus.alu_carry_out;
            flag_eq_d    = bus.alu_compare;
        end else if (bus.flag_clr) begin
            flag_carry_d = 1'b0;
            flag_eq_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_carry_q <= 1'b0;
            flag_eq_q    <= 1'b0;
        end else begin
            flag_carry_q <= flag_carry_d;
            flag_eq_q    <= flag_eq_d;
        end
    end

    assign bus.flag_carry = flag_carry_q;
    assign bus.flag_eq    = flag_eq_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_if bus();

    alu_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_pops   = 0;

    logic [17:0] exp_q[$];
    logic        model_carry;

    // Returns {carry, result, equal}.
    function automatic logic [17:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] sel, input logic mode,
                                              input logic cin);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        if (mode == MODE_LOGIC) begin
            c = 1'b0;
            case (sel)
                SEL_XOR: r = a ^ b;
                SEL_AND: r = a & b;
                default: r = a | b;
            endcase
        end else begin
            if (sel == SEL_SUB) s = {1'b0, a} + {1'b0, ~b} + 17'(cin);
            else                s = {1'b0, a} + {1'b0, b} + 17'(cin);
            r = s[15:0];
            c = s[16];
        end
        return {c, r, (a == b)};
    endfunction

    always_comb begin
        {bus.alu_carry_out, bus.alu_result, bus.alu_compare} =
            alu_model(bus.alu_in_a, bus.alu_in_b, bus.alu_select, bus.alu_mode, bus.alu_carry_in);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                          input logic mode, input logic cin, input logic chain);
        bus.op_a = a; bus.op_b = b; bus.op_sel = sel;
        bus.op_mode = mode; bus.op_cin = cin; bus.op_chain = chain;
    endtask

    // One clock with scoreboard bookkeeping; entered and left at posedge+1.
    task automatic cycle(output logic acc);
        logic [17:0] e;
        logic        c;
        @(negedge clk);
        acc = bus.op_valid && bus.op_ready;
        if (bus.res_valid && bus.res_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(bus.res_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_res_data",  32'(bus.res_data),  32'(e[16:1]));
                chk("sb_res_carry", 32'(bus.res_carry), 32'(e[17]));
                chk("sb_res_eq",    32'(bus.res_eq),    32'(e[0]));
            end
        end
        if (acc) begin
            c = bus.op_chain ? model_carry : bus.op_cin;
            e = alu_model(bus.op_a, bus.op_b, bus.op_sel, bus.op_mode, c);
            exp_q.push_back(e);
            model_carry = e[17];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        logic [15:0] a;
        logic [3:0]  sels [4];
        sels[0] = SEL_ADD; sels[1] = SEL_SUB; sels[2] = SEL_AND; sels[3] = SEL_OR;
        a = 16'($urandom);
        set_op(a, ($urandom_range(0, 3) == 0) ? a : 16'($urandom), sels[$urandom_range(0, 3)],
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic [3:0]  sel;
        logic        mode, cin, chain, clr;
        logic        exp_cin;
        logic [15:0] exp_data;
        logic        exp_carry, exp_eq;
    } vec_t;

    initial begin
        vec_t        vecs [9];
        logic        acc;
        int          k;
        logic [15:0] sa [3], sb [3];
        logic        schain [3];

        vecs[0] = '{16'h1234, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, SEL_ADD, MODE_ARITH, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, SEL_ADD, MODE_ARITH, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0F0F, SEL_XOR, MODE_LOGIC, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0};
        vecs[6] = '{16'hF0F0, 16'hFF00, SEL_AND, MODE_LOGIC, 1'b1, 1'b0, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0};
        vecs[7] = '{16'h0005, 16'h0003, SEL_SUB, MODE_ARITH, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[8] = '{16'h1234, 16'h1234, SEL_XOR, MODE_LOGIC, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};

        // Reset with an op offered
        rst = 1'b1;
        bus.op_valid = 1'b1; bus.res_ready = 1'b1; bus.flag_clr = 1'b0;
        set_op(16'h1234, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid",  32'(bus.res_valid),  32'h0);
        chk("rst_op_ready",   32'(bus.op_ready),   32'h1);
        chk("rst_flag_carry", 32'(bus.flag_carry), 32'h0);
        chk("rst_flag_eq",    32'(bus.flag_eq),    32'h0);
        chk("rst_alu_in_a",   32'(bus.alu_in_a),   32'h0);
        rst = 1'b0;
        bus.op_valid = 1'b0;

        // Directed vectors: latency, chaining and clear-vs-capture
        for (int i = 0; i < 9; i++) begin
            set_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].mode, vecs[i].cin, vecs[i].chain);
            bus.op_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d_alu_in_a", i),     32'(bus.alu_in_a),     32'(vecs[i].a));
            chk($sformatf("v%0d_alu_carry_in", i), 32'(bus.alu_carry_in), 32'(vecs[i].exp_cin));
            bus.op_valid = 1'b0;
            bus.flag_clr = vecs[i].clr;
            @(posedge clk); #1;
            bus.flag_clr = 1'b0;
            chk($sformatf("v%0d_res_valid", i),  32'(bus.res_valid),  32'h1);
            chk($sformatf("v%0d_res_data", i),   32'(bus.res_data),   32'(vecs[i].exp_data));
            chk($sformatf("v%0d_res_carry", i),  32'(bus.res_carry),  32'(vecs[i].exp_carry));
            chk($sformatf("v%0d_res_eq", i),     32'(bus.res_eq),     32'(vecs[i].exp_eq));
            chk($sformatf("v%0d_flag_carry", i), 32'(bus.flag_carry), 32'(vecs[i].exp_carry));
            chk($sformatf("v%0d_flag_eq", i),    32'(bus.flag_eq),    32'(vecs[i].exp_eq));
            @(posedge clk); #1;
        end

        // Clear alone
        bus.flag_clr = 1'b1;
        @(posedge clk); #1;
        bus.flag_clr = 1'b0;
        chk("clr_flag_carry", 32'(bus.flag_carry), 32'h0);
        chk("clr_flag_eq",    32'(bus.flag_eq),    32'h0);

        // Back-to-back ops with no backpressure
        for (int i = 0; i < 5; i++) begin
            bus.op_valid = (i < 4);
            set_op(16'(i * 16), 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0);
            #1;
            chk("b2b_op_ready", 32'(bus.op_ready), 32'h1);
            @(posedge clk); #1;
            if (i >= 1) begin
                chk("b2b_res_valid", 32'(bus.res_valid), 32'h1);
                chk("b2b_res_data",  32'(bus.res_data),  32'((i - 1) * 16 + 1));
            end
        end
        bus.op_valid = 1'b0;
        @(posedge clk); #1;

        // Stall: 3 ops offered while downstream blocks, then release
        model_carry = 1'b0;
        sa[0] = 16'h1111; sb[0] = 16'h2222; schain[0] = 1'b0;
        sa[1] = 16'hFFFF; sb[1] = 16'h0001; schain[1] = 1'b0;
        sa[2] = 16'h0000; sb[2] = 16'h0000; schain[2] = 1'b1;
        k = 0;
        n_pops = 0;
        bus.res_ready = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c == 5) bus.res_ready = 1'b1;
            bus.op_valid = (k < 3);
            if (k < 3) set_op(sa[k], sb[k], SEL_ADD, MODE_ARITH, 1'b0, schain[k]);
            cycle(acc);
            if (acc) k++;
            if (c >= 1 && c < 5) begin
                chk("stall_op_ready",  32'(bus.op_ready),  32'h0);
                chk("stall_res_valid", 32'(bus.res_valid), 32'h1);
                chk("stall_res_data",  32'(bus.res_data),  32'h3333);
            end
            if (c == 4) chk("stall_accepted", 32'(k), 32'd2);
        end
        bus.op_valid = 1'b0;
        chk("stall_all_accepted", 32'(k), 32'd3);
        chk("stall_results", 32'(n_pops), 32'd3);
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Randomised traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            bus.op_valid  = ($urandom_range(0, 9) < 7);
            bus.res_ready = ($urandom_range(0, 9) < 7);
            rand_op();
            cycle(acc);
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b1;
        repeat (4) cycle(acc);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two ops in flight
        bus.res_ready = 1'b0;
        bus.op_valid  = 1'b1;
        set_op(16'h0101, 16'h0202, SEL_ADD, MODE_ARITH, 1'b0, 1'b0);
        repeat (2) cycle(acc);
        chk("flight_op_ready", 32'(bus.op_ready), 32'h0);
        bus.op_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        bus.res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("flight_res_valid", 32'(bus.res_valid), 32'h0);
        end
        chk("flight_flag_carry", 32'(bus.flag_carry), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
